// File: rtl/crc_pkg.sv
// Shared CRC-32 definitions for the stream engine.
// Holds the reflected polynomial, the default frame constants, the frame
// state type and the table-entry generator for the byte-wise update.
package crc_pkg;

    localparam int unsigned CRC_W  = 32;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned LEN_W  = 16;

    localparam logic [CRC_W-1:0] CRC32_POLY_REFL = 32'hEDB88320;
    localparam logic [CRC_W-1:0] CRC32_INIT      = 32'hFFFFFFFF;
    localparam logic [CRC_W-1:0] CRC32_XOROUT    = 32'hFFFFFFFF;
    localparam logic [CRC_W-1:0] CRC32_RESIDUE   = 32'hDEBB20E3;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    // One table entry: the byte run through 8 reflected shift/XOR steps.
    function automatic logic [CRC_W-1:0] crc32_tbl_entry(input logic [BYTE_W-1:0] b);
        logic [CRC_W-1:0] c;
        c = {24'd0, b};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC32_POLY_REFL) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/crc32_byte_step.sv
// Combinational single-byte CRC-32 update with bypass.
// Ports:
//   i_crc_in  - running CRC register value
//   i_byte    - data byte to fold in
//   i_en      - 1: apply the byte, 0: pass i_crc_in through unchanged
//   o_crc_out - updated CRC value
module crc32_byte_step
    import crc_pkg::*;
(
    input  logic [CRC_W-1:0]  i_crc_in,
    input  logic [BYTE_W-1:0] i_byte,
    input  logic              i_en,
    output logic [CRC_W-1:0]  o_crc_out
);

    logic [CRC_W-1:0]  w_tbl [256];
    logic [BYTE_W-1:0] w_idx;

    // Lookup table built from the polynomial at elaboration.
    for (genvar g = 0; g < 256; g++) begin : g_tbl
        assign w_tbl[g] = crc32_tbl_entry(BYTE_W'(g));
    end

    assign w_idx     = i_crc_in[BYTE_W-1:0] ^ i_byte;
    assign o_crc_out = i_en ? ((i_crc_in >> 8) ^ w_tbl[w_idx]) : i_crc_in;

endmodule

// File: rtl/crc32_stream_engine.sv
// Multi-byte-per-cycle reflected CRC-32 engine with frame semantics.
// Consumes a valid/ready byte stream (keep honoured on the last beat only)
// and presents one held result per frame on a valid/ready result channel.
// Ports:
//   clk, rst_n              - clock, synchronous active-low reset
//   s_valid/s_ready         - input beat handshake
//   s_data, s_keep, s_last  - beat payload; byte 0 in s_data[7:0] goes first
//   crc_valid/crc_ready     - result handshake
//   crc_out                 - final CRC (raw ^ XOROUT)
//   crc_ok                  - raw register matched RESIDUE at frame end
//   frame_len               - byte count of the frame, saturating
module crc32_stream_engine
    import crc_pkg::*;
#(
    parameter int unsigned      DATA_BYTES = 4,
    parameter logic [CRC_W-1:0] INIT       = CRC32_INIT,
    parameter logic [CRC_W-1:0] XOROUT     = CRC32_XOROUT,
    parameter logic [CRC_W-1:0] RESIDUE    = CRC32_RESIDUE
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           s_valid,
    output logic                           s_ready,
    input  logic [BYTE_W*DATA_BYTES-1:0]   s_data,
    input  logic [DATA_BYTES-1:0]          s_keep,
    input  logic                           s_last,
    output logic                           crc_valid,
    input  logic                           crc_ready,
    output logic [CRC_W-1:0]               crc_out,
    output logic                           crc_ok,
    output logic [LEN_W-1:0]               frame_len
);

    localparam int unsigned CNT_W = $clog2(DATA_BYTES + 1);

    state_t             r_state;
    logic [CRC_W-1:0]   r_crc;
    logic [LEN_W-1:0]   r_len;
    logic [CRC_W-1:0]   r_crc_out;
    logic               r_crc_ok;
    logic [LEN_W-1:0]   r_frame_len;

    logic [DATA_BYTES-1:0] w_keep;
    logic [CRC_W-1:0]      w_chain [DATA_BYTES+1];
    logic [CNT_W-1:0]      w_cnt;
    logic [LEN_W:0]        w_len_sum;
    logic [LEN_W-1:0]      w_next_len;
    logic                  w_accept;

    // Handshake flags come from the state register; reset masks s_ready.
    assign s_ready   = rst_n && (r_state == ACCUM);
    assign crc_valid = (r_state == HOLD);
    assign w_accept  = s_valid && s_ready;

    // Mid-frame beats always carry all bytes.
    assign w_keep = s_last ? s_keep : '1;

    // Byte-step chain; disabled lanes pass the CRC through untouched.
    assign w_chain[0] = r_crc;
    for (genvar g = 0; g < DATA_BYTES; g++) begin : g_step
        crc32_byte_step u_step (
            .i_crc_in  (w_chain[g]),
            .i_byte    (s_data[BYTE_W*g +: BYTE_W]),
            .i_en      (w_keep[g]),
            .o_crc_out (w_chain[g+1])
        );
    end

    // Popcount of the effective keep.
    always_comb begin
        w_cnt = '0;
        for (int i = 0; i < DATA_BYTES; i++) begin
            w_cnt = w_cnt + CNT_W'(w_keep[i]);
        end
    end

    // Saturating length accumulate.
    assign w_len_sum  = {1'b0, r_len} + (LEN_W+1)'(w_cnt);
    assign w_next_len = w_len_sum[LEN_W] ? {LEN_W{1'b1}} : w_len_sum[LEN_W-1:0];

    // Frame FSM with registered result outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ACCUM;
            r_crc       <= INIT;
            r_len       <= '0;
            r_crc_out   <= '0;
            r_crc_ok    <= 1'b0;
            r_frame_len <= '0;
        end else begin
            case (r_state)
                ACCUM: begin
                    if (w_accept) begin
                        if (s_last) begin
                            r_crc_out   <= w_chain[DATA_BYTES] ^ XOROUT;
                            r_crc_ok    <= (w_chain[DATA_BYTES] == RESIDUE);
                            r_frame_len <= w_next_len;
                            r_crc       <= INIT;
                            r_len       <= '0;
                            r_state     <= HOLD;
                        end else begin
                            r_crc <= w_chain[DATA_BYTES];
                            r_len <= w_next_len;
                        end
                    end
                end
                HOLD: begin
                    if (crc_ready) begin
                        r_state <= ACCUM;
                    end
                end
                default: r_state <= ACCUM;
            endcase
        end
    end

    assign crc_out   = r_crc_out;
    assign crc_ok    = r_crc_ok;
    assign frame_len = r_frame_len;

endmodule

// File: tb/tb_crc32_stream_engine.sv
// Scoreboard bench for crc32_stream_engine: three instances (4, 1 and 8
// bytes per beat) share clock and reset; stimulus pushes expected results,
// a negedge monitor pops and compares on each result handshake.
module tb_crc32_stream_engine;

    typedef logic [7:0] byte_q_t[$];

    typedef struct {
        int          lane;
        logic [31:0] crc;
        logic        ok;
        logic [15:0] len;
        int          rise;
        bit          chk;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [2:0]  s_valid;
    logic [2:0]  s_ready;
    logic [2:0]  s_last;
    logic [2:0]  crc_valid;
    logic [2:0]  crc_ready;
    logic [2:0]  crc_ok;
    logic [63:0] s_data    [3];
    logic [7:0]  s_keep    [3];
    logic [31:0] crc_out   [3];
    logic [15:0] frame_len [3];

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   last_acc = 0;
    exp_t exp_q[$];
    exp_t e;
    logic [2:0] prev_v;
    int   rise_cyc [3];

    crc32_stream_engine #(.DATA_BYTES(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid[0]), .s_ready(s_ready[0]),
        .s_data(s_data[0][31:0]), .s_keep(s_keep[0][3:0]), .s_last(s_last[0]),
        .crc_valid(crc_valid[0]), .crc_ready(crc_ready[0]),
        .crc_out(crc_out[0]), .crc_ok(crc_ok[0]), .frame_len(frame_len[0])
    );

    crc32_stream_engine #(.DATA_BYTES(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid[1]), .s_ready(s_ready[1]),
        .s_data(s_data[1][7:0]), .s_keep(s_keep[1][0:0]), .s_last(s_last[1]),
        .crc_valid(crc_valid[1]), .crc_ready(crc_ready[1]),
        .crc_out(crc_out[1]), .crc_ok(crc_ok[1]), .frame_len(frame_len[1])
    );

    crc32_stream_engine #(.DATA_BYTES(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid[2]), .s_ready(s_ready[2]),
        .s_data(s_data[2]), .s_keep(s_keep[2]), .s_last(s_last[2]),
        .crc_valid(crc_valid[2]), .crc_ready(crc_ready[2]),
        .crc_out(crc_out[2]), .crc_ok(crc_ok[2]), .frame_len(frame_len[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: compare every result handshake against the scoreboard.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (!rst_n) begin
                prev_v[k] = 1'b0;
            end else begin
                if (crc_valid[k] && !prev_v[k]) rise_cyc[k] = cyc;
                prev_v[k] = crc_valid[k];
                if (crc_valid[k] && crc_ready[k]) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_result lane %0d: got crc %h with no expected entry", k, crc_out[k]);
                    end else begin
                        e = exp_q.pop_front();
                        check($sformatf("l%0d_lane", k), 64'(k), 64'(e.lane));
                        if (e.chk) begin
                            check($sformatf("l%0d_crc_out", k), 64'(crc_out[k]), 64'(e.crc));
                            check($sformatf("l%0d_crc_ok", k), 64'(crc_ok[k]), 64'(e.ok));
                        end
                        check($sformatf("l%0d_frame_len", k), 64'(frame_len[k]), 64'(e.len));
                        check($sformatf("l%0d_latency", k), 64'(rise_cyc[k]), 64'(e.rise));
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    function automatic int lane_w(input int k);
        return (k == 0) ? 4 : (k == 1) ? 1 : 8;
    endfunction

    // Drive one beat and hold it until the engine takes it.
    task automatic send_beat(input int k, input logic [63:0] d, input logic [7:0] kp, input logic last);
        int t;
        t = 0;
        tick();
        s_valid[k] = 1'b1;
        s_data[k]  = d;
        s_keep[k]  = kp;
        s_last[k]  = last;
        while (!s_ready[k] && t < 50) begin
            tick();
            t++;
        end
        if (!s_ready[k]) begin
            checks++;
            failures++;
            $display("FAIL s_ready_timeout lane %0d: got s_ready 0 expected 1", k);
        end
        last_acc = cyc;
    endtask

    task automatic push_exp(input int k, input logic [31:0] crc, input logic ok,
                            input logic [15:0] len, input bit chk);
        exp_t x;
        x.lane = k; x.crc = crc; x.ok = ok; x.len = len; x.rise = last_acc + 1; x.chk = chk;
        exp_q.push_back(x);
    endtask

    task automatic send_frame(input int k, input byte_q_t q, input logic [31:0] crc,
                              input logic ok, input logic [15:0] len);
        int w, n, idx;
        logic [63:0] d;
        logic [7:0]  kp;
        w = lane_w(k);
        n = q.size();
        idx = 0;
        if (n == 0) begin
            send_beat(k, 64'd0, 8'd0, 1'b1);
        end else begin
            while (idx < n) begin
                d = '0;
                kp = '0;
                for (int j = 0; j < w; j++) begin
                    if (idx + j < n) begin
                        d[8*j +: 8] = q[idx + j];
                        kp[j] = 1'b1;
                    end
                end
                send_beat(k, d, kp, (idx + w >= n));
                idx += w;
            end
        end
        push_exp(k, crc, ok, len, 1'b1);
    endtask

    task automatic idle(input int k);
        tick();
        s_valid[k] = 1'b0;
        s_last[k]  = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 200) begin
            tick();
            t++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout: got %0d pending results expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    // Reset after the first beat of a frame, then a clean "123456789".
    task automatic reset_mid(input int k, input logic [63:0] first, input byte_q_t s9);
        send_beat(k, first, 8'hFF, 1'b0);
        tick();
        s_valid[k] = 1'b0;
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("l%0d_rst_s_ready", k), 64'(s_ready[k]), 64'd0);
            check($sformatf("l%0d_rst_crc_valid", k), 64'(crc_valid[k]), 64'd0);
        end
        rst_n = 1'b1;
        tick();
        check($sformatf("l%0d_rel_s_ready", k), 64'(s_ready[k]), 64'd1);
        check($sformatf("l%0d_rel_crc_valid", k), 64'(crc_valid[k]), 64'd0);
        send_frame(k, s9, 32'hCBF43926, 1'b0, 16'd9);
        idle(k);
        drain();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        byte_q_t s9, s13, z1, empty_q;
        s9  = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        s13 = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
                8'h26, 8'h39, 8'hF4, 8'hCB};
        z1  = '{8'h00};
        empty_q = {};

        rst_n     = 1'b0;
        s_valid   = '0;
        s_last    = '0;
        crc_ready = 3'b111;
        for (int k = 0; k < 3; k++) begin
            s_data[k] = '0;
            s_keep[k] = '0;
        end
        repeat (3) tick();

        // Reset values on all three instances.
        for (int k = 0; k < 3; k++) begin
            check($sformatf("l%0d_reset_s_ready", k), 64'(s_ready[k]), 64'd0);
            check($sformatf("l%0d_reset_crc_valid", k), 64'(crc_valid[k]), 64'd0);
            check($sformatf("l%0d_reset_crc_out", k), 64'(crc_out[k]), 64'd0);
            check($sformatf("l%0d_reset_crc_ok", k), 64'(crc_ok[k]), 64'd0);
            check($sformatf("l%0d_reset_frame_len", k), 64'(frame_len[k]), 64'd0);
        end
        rst_n = 1'b1;
        tick();
        for (int k = 0; k < 3; k++) begin
            check($sformatf("l%0d_release_s_ready", k), 64'(s_ready[k]), 64'd1);
        end

        // 4-byte lane: basic frames.
        send_frame(0, s9, 32'hCBF43926, 1'b0, 16'd9);
        idle(0); drain();
        send_frame(0, z1, 32'hD202EF8D, 1'b0, 16'd1);
        idle(0); drain();
        send_frame(0, empty_q, 32'h00000000, 1'b0, 16'd0);
        idle(0); drain();
        send_frame(0, s13, 32'h2144DF1C, 1'b1, 16'd13);
        idle(0); drain();

        // Last byte placed in lane 3 only: skipped lanes must not feed zeros.
        send_beat(0, 64'h34333231, 8'h0F, 1'b0);
        send_beat(0, 64'h38373635, 8'h0F, 1'b0);
        send_beat(0, 64'h39000000, 8'h08, 1'b1);
        push_exp(0, 32'hCBF43926, 1'b0, 16'd9, 1'b1);
        idle(0); drain();

        // Backpressure: result held, next beat held off, then resumes.
        crc_ready[0] = 1'b0;
        send_frame(0, s9, 32'hCBF43926, 1'b0, 16'd9);
        tick();
        s_valid[0] = 1'b1;
        s_data[0]  = 64'h34333231;
        s_keep[0]  = 8'h0F;
        s_last[0]  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("bp_s_ready", 64'(s_ready[0]), 64'd0);
            check("bp_crc_valid", 64'(crc_valid[0]), 64'd1);
            check("bp_crc_out", 64'(crc_out[0]), 64'hCBF43926);
            check("bp_frame_len", 64'(frame_len[0]), 64'd9);
            tick();
        end
        crc_ready[0] = 1'b1;
        send_frame(0, s9, 32'hCBF43926, 1'b0, 16'd9);
        idle(0); drain();

        // Reset mid-frame on each width.
        reset_mid(0, 64'h34333231, s9);
        reset_mid(1, 64'h31, s9);
        reset_mid(2, 64'h3837363534333231, s9);

        // 8-byte lane: plain frame and length saturation.
        send_frame(2, s9, 32'hCBF43926, 1'b0, 16'd9);
        idle(2); drain();
        for (int i = 0; i < 8200; i++) begin
            send_beat(2, 64'd0, 8'hFF, (i == 8199));
        end
        push_exp(2, 32'd0, 1'b0, 16'hFFFF, 1'b0);
        idle(2); drain();

        repeat (3) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
